// File: rtl/bch_berlekamp_sched.sv
// Shares one Berlekamp (SiBM) core among NCH syndrome channels: per-channel one-entry
// buffers, round-robin issue, watchdog on the core result, channel-tagged forwarding.
module bch_berlekamp_sched #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned M       = 8,
    parameter int unsigned T       = 8,
    parameter int unsigned PTR_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic [NCH-1:0]             isyn_val,
    input  logic [NCH*2*T*M-1:0]       isyn,
    output logic [NCH-1:0]             osyn_rdy,
    output logic                       osib_syndrome_val,
    output logic [2*T*M-1:0]           osib_syndrome,
    input  logic                       isib_loc_poly_val,
    input  logic [(T+1)*M-1:0]         isib_loc_poly,
    input  logic [PTR_W-1:0]           isib_loc_poly_ptr,
    input  logic                       isib_failed,
    output logic                       oloc_poly_val,
    output logic [(T+1)*M-1:0]         oloc_poly,
    output logic [PTR_W-1:0]           oloc_poly_ptr,
    output logic                       oloc_failed,
    output logic [$clog2(NCH)-1:0]     oloc_chan,
    output logic [7:0]                 otimeout_cnt
);

    localparam int unsigned SYN_W  = 2 * T * M;
    localparam int unsigned POLY_W = (T + 1) * M;
    localparam int unsigned CH_W   = $clog2(NCH);
    localparam int unsigned WD_W   = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [NCH-1:0]    full_q, full_d;
    logic [SYN_W-1:0]  buf_q [NCH];
    logic [SYN_W-1:0]  buf_d [NCH];
    logic              syn_val_q, syn_val_d;
    logic [SYN_W-1:0]  syn_q, syn_d;
    logic              lp_val_q, lp_val_d;
    logic [POLY_W-1:0] lp_q, lp_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              fail_q, fail_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [7:0]        tocnt_q, tocnt_d;

    logic              arb_found;
    logic [CH_W-1:0]   arb_sel;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    // Round-robin pick: scanning downward lets the entry nearest rr_q+1 win.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        for (int unsigned i = NCH; i >= 1; i--) begin
            if (full_q[wrap_add(rr_q, i)]) begin
                arb_found = 1'b1;
                arb_sel   = wrap_add(rr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        full_d    = full_q;
        buf_d     = buf_q;
        syn_val_d = 1'b0;
        syn_d     = syn_q;
        lp_val_d  = 1'b0;
        lp_d      = lp_q;
        ptr_d     = ptr_q;
        fail_d    = fail_q;
        chan_d    = chan_q;
        tocnt_d   = tocnt_q;

        for (int unsigned c = 0; c < NCH; c++) begin
            if (isyn_val[c] && !full_q[c]) begin
                full_d[c] = 1'b1;
                buf_d[c]  = isyn[c*SYN_W +: SYN_W];
            end
        end

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    sel_d     = arb_sel;
                    rr_d      = arb_sel;
                    syn_val_d = 1'b1;
                    syn_d     = buf_q[arb_sel];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                full_d[sel_q] = 1'b0;
                wd_d          = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                // A result in the final watchdog cycle still beats the timeout.
                if (isib_loc_poly_val) begin
                    lp_val_d = 1'b1;
                    lp_d     = isib_loc_poly;
                    ptr_d    = isib_loc_poly_ptr;
                    fail_d   = isib_failed;
                    chan_d   = sel_q;
                    state_d  = DONE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    lp_val_d = 1'b1;
                    lp_d     = '0;
                    ptr_d    = '0;
                    fail_d   = 1'b1;
                    chan_d   = sel_q;
                    if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                    state_d  = DONE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            rr_q      <= CH_W'(NCH - 1);
            wd_q      <= '0;
            full_q    <= '0;
            for (int unsigned c = 0; c < NCH; c++) buf_q[c] <= '0;
            syn_val_q <= 1'b0;
            syn_q     <= '0;
            lp_val_q  <= 1'b0;
            lp_q      <= '0;
            ptr_q     <= '0;
            fail_q    <= 1'b0;
            chan_q    <= '0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            full_q    <= full_d;
            for (int unsigned c = 0; c < NCH; c++) buf_q[c] <= buf_d[c];
            syn_val_q <= syn_val_d;
            syn_q     <= syn_d;
            lp_val_q  <= lp_val_d;
            lp_q      <= lp_d;
            ptr_q     <= ptr_d;
            fail_q    <= fail_d;
            chan_q    <= chan_d;
            tocnt_q   <= tocnt_d;
        end
    end

    assign osyn_rdy          = ~full_q;
    assign osib_syndrome_val = syn_val_q;
    assign osib_syndrome     = syn_q;
    assign oloc_poly_val     = lp_val_q;
    assign oloc_poly         = lp_q;
    assign oloc_poly_ptr     = ptr_q;
    assign oloc_failed       = fail_q;
    assign oloc_chan         = chan_q;
    assign otimeout_cnt      = tocnt_q;

endmodule

// File: tb/tb_bch_berlekamp_sched.sv
// Directed bench for bch_berlekamp_sched; the Berlekamp core is modelled by driving
// the isib_* inputs with hand-chosen results at chosen cycles.
module tb_bch_berlekamp_sched;

    localparam int unsigned NCH     = 4;
    localparam int unsigned M       = 8;
    localparam int unsigned T       = 8;
    localparam int unsigned PTR_W   = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned SYN_W   = 2 * T * M;
    localparam int unsigned POLY_W  = (T + 1) * M;
    localparam int unsigned CH_W    = $clog2(NCH);

    logic                   iclk   = 1'b0;
    logic                   ireset = 1'b0;
    logic [NCH-1:0]         isyn_val = '0;
    logic [NCH*SYN_W-1:0]   isyn = '0;
    logic [NCH-1:0]         osyn_rdy;
    logic                   osib_syndrome_val;
    logic [SYN_W-1:0]       osib_syndrome;
    logic                   isib_loc_poly_val = 1'b0;
    logic [POLY_W-1:0]      isib_loc_poly = '0;
    logic [PTR_W-1:0]       isib_loc_poly_ptr = '0;
    logic                   isib_failed = 1'b0;
    logic                   oloc_poly_val;
    logic [POLY_W-1:0]      oloc_poly;
    logic [PTR_W-1:0]       oloc_poly_ptr;
    logic                   oloc_failed;
    logic [CH_W-1:0]        oloc_chan;
    logic [7:0]             otimeout_cnt;

    int errors = 0;
    int checks = 0;

    bch_berlekamp_sched #(
        .NCH(NCH), .M(M), .T(T), .PTR_W(PTR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .iclk              (iclk),
        .ireset            (ireset),
        .isyn_val          (isyn_val),
        .isyn              (isyn),
        .osyn_rdy          (osyn_rdy),
        .osib_syndrome_val (osib_syndrome_val),
        .osib_syndrome     (osib_syndrome),
        .isib_loc_poly_val (isib_loc_poly_val),
        .isib_loc_poly     (isib_loc_poly),
        .isib_loc_poly_ptr (isib_loc_poly_ptr),
        .isib_failed       (isib_failed),
        .oloc_poly_val     (oloc_poly_val),
        .oloc_poly         (oloc_poly),
        .oloc_poly_ptr     (oloc_poly_ptr),
        .oloc_failed       (oloc_failed),
        .oloc_chan         (oloc_chan),
        .otimeout_cnt      (otimeout_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge iclk);
    endtask

    task automatic set_syn(input int c, input logic [SYN_W-1:0] v);
        isyn[c*SYN_W +: SYN_W] = v;
    endtask

    task automatic wait_issue(input string tag, input logic [SYN_W-1:0] exp_syn);
        int n = 0;
        while (osib_syndrome_val !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, 128'(osib_syndrome_val), 128'(1));
        check({tag, "_syn"}, 128'(osib_syndrome), 128'(exp_syn));
    endtask

    // Called in the first WAIT cycle; result is presented dly cycles later for one cycle.
    task automatic core_reply(input int dly, input logic [POLY_W-1:0] p,
                              input logic [PTR_W-1:0] ptr, input logic f);
        repeat (dly) tick();
        isib_loc_poly_val = 1'b1;
        isib_loc_poly     = p;
        isib_loc_poly_ptr = ptr;
        isib_failed       = f;
        tick();
        isib_loc_poly_val = 1'b0;
        isib_failed       = 1'b0;
    endtask

    task automatic check_done(input string tag, input int chan, input logic [POLY_W-1:0] p,
                              input logic [PTR_W-1:0] ptr, input logic f);
        check({tag, "_val"}, 128'(oloc_poly_val), 128'(1));
        check({tag, "_chan"}, 128'(oloc_chan), 128'(chan));
        check({tag, "_poly"}, 128'(oloc_poly), 128'(p));
        check({tag, "_ptr"}, 128'(oloc_poly_ptr), 128'(ptr));
        check({tag, "_failed"}, 128'(oloc_failed), 128'(f));
        tick();
        check({tag, "_val_once"}, 128'(oloc_poly_val), 128'(0));
    endtask

    task automatic do_reset();
        ireset = 1'b0;
        tick();
        tick();
        ireset = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, 128'(osyn_rdy), 128'(4'hF));
        check({tag, "_sibval"}, 128'(osib_syndrome_val), 128'(0));
        check({tag, "_sibsyn"}, 128'(osib_syndrome), 128'(0));
        check({tag, "_lpval"}, 128'(oloc_poly_val), 128'(0));
        check({tag, "_poly"}, 128'(oloc_poly), 128'(0));
        check({tag, "_ptr"}, 128'(oloc_poly_ptr), 128'(0));
        check({tag, "_failed"}, 128'(oloc_failed), 128'(0));
        check({tag, "_chan"}, 128'(oloc_chan), 128'(0));
        check({tag, "_tocnt"}, 128'(otimeout_cnt), 128'(0));
    endtask

    initial begin
        int n;

        // Reset state
        tick();
        check_reset_outputs("rst");
        ireset = 1'b1;
        tick();

        // Single job on channel 0 with exact issue latency
        isyn_val = 4'b0001;
        set_syn(0, 128'h05);
        tick();
        isyn_val = 4'b0000;
        check("single_rdy_full", 128'(osyn_rdy), 128'(4'b1110));
        check("single_noissue", 128'(osib_syndrome_val), 128'(0));
        tick();
        check("single_issue", 128'(osib_syndrome_val), 128'(1));
        check("single_syn", 128'(osib_syndrome), 128'h05);
        tick();
        check("single_issue_once", 128'(osib_syndrome_val), 128'(0));
        check("single_rdy_back", 128'(osyn_rdy), 128'(4'hF));
        check("single_syn_hold", 128'(osib_syndrome), 128'h05);
        core_reply(7, 72'h0501, 4'd0, 1'b0);
        check_done("single", 0, 72'h0501, 4'd0, 1'b0);

        // Round-robin with all channels held valid
        do_reset();
        isyn_val = 4'hF;
        for (int c = 0; c < 4; c++) set_syn(c, SYN_W'(8'h10 + c));
        for (int g = 0; g < 5; g++) begin
            int c;
            c = g % 4;
            wait_issue("rr", SYN_W'(8'h10 + c));
            tick();
            check("rr_rdy_rise", 128'(osyn_rdy[c]), 128'(1));
            core_reply(1, POLY_W'(g + 1), PTR_W'(c), 1'b0);
            check_done("rr", c, POLY_W'(g + 1), PTR_W'(c), 1'b0);
        end
        isyn_val = 4'h0;
        do_reset();

        // Channel 2 refills while its own job is in flight
        isyn_val = 4'b0100;
        set_syn(2, 128'h22);
        tick();
        isyn_val = 4'b0000;
        wait_issue("rf1", 128'h22);
        tick();
        isyn_val = 4'b0100;
        set_syn(2, 128'h23);
        tick();
        isyn_val = 4'b0000;
        check("rf_full_in_wait", 128'(osyn_rdy), 128'(4'b1011));
        core_reply(3, 72'h1234, 4'd2, 1'b0);
        check_done("rf1", 2, 72'h1234, 4'd2, 1'b0);
        wait_issue("rf2", 128'h23);
        tick();
        core_reply(0, 72'h0301, 4'd1, 1'b0);
        check_done("rf2", 2, 72'h0301, 4'd1, 1'b0);

        // Core failure flag passes through with the polynomial
        isyn_val = 4'b1000;
        set_syn(3, 128'h33);
        tick();
        isyn_val = 4'b0000;
        wait_issue("fp", 128'h33);
        tick();
        core_reply(4, 72'h070301, 4'd3, 1'b1);
        check_done("fp", 3, 72'h070301, 4'd3, 1'b1);

        // Result in the last watchdog cycle wins over the timeout
        isyn_val = 4'b0001;
        set_syn(0, 128'h44);
        tick();
        isyn_val = 4'b0000;
        wait_issue("bnd", 128'h44);
        tick();
        core_reply(TIMEOUT - 1, 72'h0a0b, 4'd5, 1'b0);
        check_done("bnd", 0, 72'h0a0b, 4'd5, 1'b0);
        check("bnd_tocnt", 128'(otimeout_cnt), 128'(0));

        // Core never answers: timeout result
        isyn_val = 4'b0010;
        set_syn(1, 128'h55);
        tick();
        isyn_val = 4'b0000;
        wait_issue("to", 128'h55);
        n = 0;
        while (oloc_poly_val !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("to_latency", 128'(n), 128'(TIMEOUT + 1));
        check("to_tocnt", 128'(otimeout_cnt), 128'(1));
        check_done("to", 1, '0, '0, 1'b1);
        isib_loc_poly_val = 1'b1;
        isib_loc_poly     = 72'hff;
        tick();
        isib_loc_poly_val = 1'b0;
        check("late_ignored", 128'(oloc_poly_val), 128'(0));
        tick();
        check("late_ignored2", 128'(oloc_poly_val), 128'(0));
        check("late_noissue", 128'(osib_syndrome_val), 128'(0));
        check("late_tocnt", 128'(otimeout_cnt), 128'(1));

        // Reset during WAIT with three buffers full
        isyn_val = 4'b1110;
        set_syn(1, 128'h61);
        set_syn(2, 128'h62);
        set_syn(3, 128'h63);
        wait_issue("rm", 128'h62);
        tick();
        tick();
        check("rm_three_full", 128'(osyn_rdy), 128'(4'b0001));
        isyn_val = 4'b0000;
        #2;
        ireset = 1'b0;
        #1;
        check_reset_outputs("rm");
        tick();
        ireset = 1'b1;
        isyn_val = 4'b1001;
        set_syn(0, 128'h70);
        set_syn(3, 128'h73);
        tick();
        isyn_val = 4'b0000;
        wait_issue("rm_next", 128'h70);
        tick();
        core_reply(2, 72'h0701, 4'd1, 1'b0);
        check_done("rm_next", 0, 72'h0701, 4'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
